// File: rtl/fetch_controller.sv
// Instruction fetch controller: two-word boot vector, sequential fetch, hold and redirect.
// Optional FETCH_IMM_EN adds 2-word instructions (opcode word with bit0=1 followed by an immediate word).
module fetch_controller #(
  parameter logic [31:0] BOOT_ADDR = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] memInstruction,
  output logic [31:0] readAddress,
  output logic        memStall,
  input  logic        hazardStall,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget,
  output logic [15:0] instrOut,
  output logic [15:0] immOut,
  output logic        instrValid,
  output logic [31:0] pcOut
);

`ifdef FETCH_IMM_EN
  typedef enum logic [1:0] {BOOT_HI, BOOT_LO, RUN, IMM} state_t;
`else
  typedef enum logic [1:0] {BOOT_HI, BOOT_LO, RUN} state_t;
`endif

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [15:0] instr_nxt;
  logic [31:0] pcout_nxt;
  logic        valid_nxt;
  logic        in_fetch;
  logic        redirect;
  logic        held;

`ifdef FETCH_IMM_EN
  logic [15:0] imm_q, imm_nxt;
  logic        two_word;

  assign two_word = memInstruction[0];
  assign immOut   = imm_q;
`else
  assign immOut   = 16'h0000;
`endif

  // Redirect outranks the hazard hold; both only matter once the boot vector is loaded.
  always_comb begin
`ifdef FETCH_IMM_EN
    in_fetch = (state == RUN) || (state == IMM);
`else
    in_fetch = (state == RUN);
`endif
    redirect = in_fetch && branchTaken;
    held     = in_fetch && hazardStall && !branchTaken;
    memStall = redirect || held;
  end

  always_comb begin
    unique case (state)
      BOOT_HI: readAddress = BOOT_ADDR;
      BOOT_LO: readAddress = BOOT_ADDR + 32'd1;
      default: readAddress = pc;
    endcase
  end

  always_comb begin
    // NOTE: every output of this block gets its hold value first, so no path can infer a latch.
    state_nxt = state;
    pc_nxt    = pc;
    instr_nxt = instrOut;
    pcout_nxt = pcOut;
    valid_nxt = instrValid;
`ifdef FETCH_IMM_EN
    imm_nxt   = imm_q;
`endif

    if (redirect) begin
      pc_nxt    = branchTarget;
      state_nxt = RUN;
      valid_nxt = 1'b0;
    end else if (!held) begin
      case (state)
        BOOT_HI: begin
          pc_nxt[31:16] = memInstruction;
          valid_nxt     = 1'b0;
          state_nxt     = BOOT_LO;
        end
        BOOT_LO: begin
          pc_nxt[15:0] = memInstruction;
          valid_nxt    = 1'b0;
          state_nxt    = RUN;
        end
        RUN: begin
          instr_nxt = memInstruction;
          pcout_nxt = pc;
          pc_nxt    = pc + 32'd1;
          valid_nxt = 1'b1;
`ifdef FETCH_IMM_EN
          if (two_word) begin
            valid_nxt = 1'b0;
            state_nxt = IMM;
          end
`endif
        end
`ifdef FETCH_IMM_EN
        IMM: begin
          imm_nxt   = memInstruction;
          pc_nxt    = pc + 32'd1;
          valid_nxt = 1'b1;
          state_nxt = RUN;
        end
`endif
        default: begin
          valid_nxt = 1'b0;
          state_nxt = BOOT_HI;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= BOOT_HI;
      pc         <= 32'd0;
      instrOut   <= 16'h0000;
      pcOut      <= 32'd0;
      instrValid <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      instrOut   <= instr_nxt;
      pcOut      <= pcout_nxt;
      instrValid <= valid_nxt;
    end
  end

`ifdef FETCH_IMM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) imm_q <= 16'h0000;
    else       imm_q <= imm_nxt;
  end
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed scenarios plus a randomized run against a cycle model.
module tb_fetch_controller;

  localparam logic [31:0] BOOT = 32'd0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] memInstruction;
  logic [31:0] readAddress;
  logic        memStall;
  logic        hazardStall = 1'b0;
  logic        branchTaken = 1'b0;
  logic [31:0] branchTarget = 32'd0;
  logic [15:0] instrOut;
  logic [15:0] immOut;
  logic        instrValid;
  logic [31:0] pcOut;

  logic [15:0] ram [0:1023];
  int n_cmp = 0;
  int n_bad = 0;

  assign memInstruction = ram[readAddress[9:0]];

  always #5 clk = ~clk;

  fetch_controller #(.BOOT_ADDR(BOOT)) dut (
    .clk(clk), .reset(reset), .memInstruction(memInstruction),
    .readAddress(readAddress), .memStall(memStall),
    .hazardStall(hazardStall), .branchTaken(branchTaken), .branchTarget(branchTarget),
    .instrOut(instrOut), .immOut(immOut), .instrValid(instrValid), .pcOut(pcOut)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reset then load the boot vector; returns one cycle before the first fetch from addr.
  task automatic boot_to(input logic [31:0] addr);
    ram[BOOT[9:0]]         = addr[31:16];
    ram[BOOT[9:0] + 10'd1] = addr[15:0];
    hazardStall = 1'b0;
    branchTaken = 1'b0;
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    next_cycle();
    next_cycle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    hazardStall = 1'b1;
    branchTaken = 1'b1;
    next_cycle();
    next_cycle();
    n_cmp++; if (instrValid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", instrValid); end
    n_cmp++; if (instrOut !== 16'h0) begin n_bad++; $display("FAIL reset_instr: got %h want 0000", instrOut); end
    n_cmp++; if (immOut !== 16'h0) begin n_bad++; $display("FAIL reset_imm: got %h want 0000", immOut); end
    n_cmp++; if (pcOut !== 32'h0) begin n_bad++; $display("FAIL reset_pcout: got %h want 0", pcOut); end
    n_cmp++; if (readAddress !== BOOT) begin n_bad++; $display("FAIL reset_addr: got %h want %h", readAddress, BOOT); end
    n_cmp++; if (memStall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", memStall); end
  endtask

  task automatic test_boot();
    ram[0] = 16'h0000;
    ram[1] = 16'h0010;
    ram[16'h10] = 16'h1234;
    ram[16'h11] = 16'h2222;
    // hold and redirect requests during boot must have no effect
    hazardStall = 1'b1;
    branchTaken = 1'b1;
    branchTarget = 32'h300;
    reset = 1'b0;
    #1;
    n_cmp++; if (readAddress !== 32'h0) begin n_bad++; $display("FAIL boot_addr_hi: got %h want 0", readAddress); end
    n_cmp++; if (memStall !== 1'b0) begin n_bad++; $display("FAIL boot_stall_hi: got %b want 0", memStall); end
    next_cycle();
    n_cmp++; if (readAddress !== 32'h1) begin n_bad++; $display("FAIL boot_addr_lo: got %h want 1", readAddress); end
    n_cmp++; if (memStall !== 1'b0) begin n_bad++; $display("FAIL boot_stall_lo: got %b want 0", memStall); end
    n_cmp++; if (instrValid !== 1'b0) begin n_bad++; $display("FAIL boot_valid_lo: got %b want 0", instrValid); end
    hazardStall = 1'b0;
    branchTaken = 1'b0;
    next_cycle();
    n_cmp++; if (readAddress !== 32'h10) begin n_bad++; $display("FAIL boot_addr_run: got %h want 10", readAddress); end
    n_cmp++; if (instrValid !== 1'b0) begin n_bad++; $display("FAIL boot_valid_run: got %b want 0", instrValid); end
    next_cycle();
    n_cmp++; if (instrValid !== 1'b1) begin n_bad++; $display("FAIL first_valid: got %b want 1", instrValid); end
    n_cmp++; if (pcOut !== 32'h10) begin n_bad++; $display("FAIL first_pcout: got %h want 10", pcOut); end
    n_cmp++; if (instrOut !== 16'h1234) begin n_bad++; $display("FAIL first_instr: got %h want 1234", instrOut); end
    n_cmp++; if (readAddress !== 32'h11) begin n_bad++; $display("FAIL first_next: got %h want 11", readAddress); end
  endtask

  task automatic test_two_word();
    ram[16'h10] = 16'h1235;
    ram[16'h11] = 16'hBEEF;
    ram[16'h12] = 16'h0002;
    boot_to(32'h10);
    next_cycle();
`ifdef FETCH_IMM_EN
    n_cmp++; if (instrValid !== 1'b0) begin n_bad++; $display("FAIL tw_mid_valid: got %b want 0", instrValid); end
    n_cmp++; if (readAddress !== 32'h11) begin n_bad++; $display("FAIL tw_mid_addr: got %h want 11", readAddress); end
    next_cycle();
    n_cmp++; if (instrValid !== 1'b1) begin n_bad++; $display("FAIL tw_valid: got %b want 1", instrValid); end
    n_cmp++; if (instrOut !== 16'h1235) begin n_bad++; $display("FAIL tw_instr: got %h want 1235", instrOut); end
    n_cmp++; if (immOut !== 16'hBEEF) begin n_bad++; $display("FAIL tw_imm: got %h want beef", immOut); end
    n_cmp++; if (pcOut !== 32'h10) begin n_bad++; $display("FAIL tw_pcout: got %h want 10", pcOut); end
    n_cmp++; if (readAddress !== 32'h12) begin n_bad++; $display("FAIL tw_next: got %h want 12", readAddress); end
`else
    n_cmp++; if (instrValid !== 1'b1) begin n_bad++; $display("FAIL ow_valid: got %b want 1", instrValid); end
    n_cmp++; if (instrOut !== 16'h1235) begin n_bad++; $display("FAIL ow_instr: got %h want 1235", instrOut); end
    n_cmp++; if (pcOut !== 32'h10) begin n_bad++; $display("FAIL ow_pcout: got %h want 10", pcOut); end
    n_cmp++; if (readAddress !== 32'h11) begin n_bad++; $display("FAIL ow_next: got %h want 11", readAddress); end
    next_cycle();
    n_cmp++; if (instrOut !== 16'hBEEF) begin n_bad++; $display("FAIL ow_instr2: got %h want beef", instrOut); end
    n_cmp++; if (pcOut !== 32'h11) begin n_bad++; $display("FAIL ow_pcout2: got %h want 11", pcOut); end
    n_cmp++; if (immOut !== 16'h0) begin n_bad++; $display("FAIL ow_imm: got %h want 0000", immOut); end
`endif
  endtask

  task automatic test_hazard();
    ram[16'h13] = 16'h0A0A;
    ram[16'h14] = 16'h0C0C;
    boot_to(32'h13);
    next_cycle();
    hazardStall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (memStall !== 1'b1) begin n_bad++; $display("FAIL hz_stall[%0d]: got %b want 1", i, memStall); end
      next_cycle();
      n_cmp++; if (readAddress !== 32'h14) begin n_bad++; $display("FAIL hz_addr[%0d]: got %h want 14", i, readAddress); end
      n_cmp++; if (instrValid !== 1'b1 || pcOut !== 32'h13 || instrOut !== 16'h0A0A) begin
        n_bad++; $display("FAIL hz_frozen[%0d]: got v=%b pc=%h i=%h want v=1 pc=13 i=0a0a", i, instrValid, pcOut, instrOut);
      end
    end
    hazardStall = 1'b0;
    #1;
    n_cmp++; if (memStall !== 1'b0) begin n_bad++; $display("FAIL hz_release: got %b want 0", memStall); end
    next_cycle();
    n_cmp++; if (pcOut !== 32'h14 || instrOut !== 16'h0C0C) begin
      n_bad++; $display("FAIL hz_resume: got pc=%h i=%h want pc=14 i=0c0c", pcOut, instrOut);
    end
  endtask

  task automatic test_branch();
    ram[16'h40]  = 16'h0004;
    ram[16'h41]  = 16'h0006;
    ram[16'h200] = 16'h7770;
    boot_to(32'h40);
    next_cycle();
    hazardStall = 1'b1;
    branchTaken = 1'b1;
    branchTarget = 32'h200;
    #1;
    n_cmp++; if (memStall !== 1'b1) begin n_bad++; $display("FAIL br_stall: got %b want 1", memStall); end
    next_cycle();
    hazardStall = 1'b0;
    branchTaken = 1'b0;
    n_cmp++; if (readAddress !== 32'h200) begin n_bad++; $display("FAIL br_addr: got %h want 200", readAddress); end
    n_cmp++; if (instrValid !== 1'b0) begin n_bad++; $display("FAIL br_flush: got %b want 0", instrValid); end
    next_cycle();
    n_cmp++; if (instrValid !== 1'b1 || pcOut !== 32'h200 || instrOut !== 16'h7770) begin
      n_bad++; $display("FAIL br_target: got v=%b pc=%h i=%h want v=1 pc=200 i=7770", instrValid, pcOut, instrOut);
    end
  endtask

  task automatic test_wrap();
    ram[1023] = 16'h0006;
    boot_to(32'hFFFF_FFFF);
    n_cmp++; if (readAddress !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL wrap_start: got %h want ffffffff", readAddress); end
    next_cycle();
    n_cmp++; if (readAddress !== 32'h0) begin n_bad++; $display("FAIL wrap_next: got %h want 0", readAddress); end
    n_cmp++; if (pcOut !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL wrap_pcout: got %h want ffffffff", pcOut); end
  endtask

  task automatic test_reset_mid();
    ram[16'h20] = 16'h0031;
    boot_to(32'h20);
    next_cycle();
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if (instrValid !== 1'b0) begin n_bad++; $display("FAIL rmid_valid: got %b want 0", instrValid); end
    n_cmp++; if (readAddress !== BOOT) begin n_bad++; $display("FAIL rmid_addr: got %h want %h", readAddress, BOOT); end
    n_cmp++; if (pcOut !== 32'h0 || instrOut !== 16'h0) begin
      n_bad++; $display("FAIL rmid_regs: got pc=%h i=%h want 0", pcOut, instrOut);
    end
    next_cycle();
    reset = 1'b0;
    #1;
    n_cmp++; if (readAddress !== BOOT) begin n_bad++; $display("FAIL rmid_reboot_hi: got %h want %h", readAddress, BOOT); end
    next_cycle();
    n_cmp++; if (readAddress !== BOOT + 32'd1) begin n_bad++; $display("FAIL rmid_reboot_lo: got %h want %h", readAddress, BOOT + 32'd1); end
  endtask

  // Model tracks boot progress, the program counter, and whether an immediate word is still owed.
  task automatic test_random();
    int          boot_words;
    logic [31:0] m_pc, m_pcout, exp_addr;
    logic [15:0] m_instr, m_imm, w;
    logic        m_valid, m_owed, hz, br, exp_stall;
    logic [31:0] tgt;
    for (int i = 0; i < 1024; i++) ram[i] = 16'($urandom);
    ram[0] = 16'h0000;
    ram[1] = 16'($urandom_range(2, 1000));
    hazardStall = 1'b0;
    branchTaken = 1'b0;
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    boot_words = 0; m_pc = 0; m_pcout = 0; m_instr = 0; m_imm = 0; m_valid = 0; m_owed = 0;
    for (int c = 0; c < 600; c++) begin
      hz  = ($urandom_range(0, 3) == 0);
      br  = ($urandom_range(0, 9) == 0);
      tgt = (c % 3 == 0) ? $urandom : 32'($urandom_range(0, 2047));
      hazardStall = hz;
      branchTaken = br;
      branchTarget = tgt;
      #1;
      exp_addr  = (boot_words < 2) ? BOOT + 32'(boot_words) : m_pc;
      exp_stall = (boot_words == 2) && (hz || br);
      n_cmp++; if (readAddress !== exp_addr) begin n_bad++; $display("FAIL rnd_addr c%0d: got %h want %h", c, readAddress, exp_addr); end
      n_cmp++; if (memStall !== exp_stall) begin n_bad++; $display("FAIL rnd_stall c%0d: got %b want %b", c, memStall, exp_stall); end
      n_cmp++; if (instrValid !== m_valid) begin n_bad++; $display("FAIL rnd_valid c%0d: got %b want %b", c, instrValid, m_valid); end
      if (m_valid) begin
        n_cmp++; if (pcOut !== m_pcout || instrOut !== m_instr || immOut !== m_imm) begin
          n_bad++; $display("FAIL rnd_out c%0d: got pc=%h i=%h m=%h want pc=%h i=%h m=%h", c, pcOut, instrOut, immOut, m_pcout, m_instr, m_imm);
        end
      end
      w = ram[exp_addr[9:0]];
      if (boot_words == 0) begin
        m_pc = {w, m_pc[15:0]};
        boot_words = 1;
      end else if (boot_words == 1) begin
        m_pc = {m_pc[31:16], w};
        boot_words = 2;
      end else if (br) begin
        m_pc = tgt; m_valid = 0; m_owed = 0;
      end else if (!hz) begin
        if (m_owed) begin
          m_imm = w; m_owed = 0; m_valid = 1;
        end else begin
          m_instr = w; m_pcout = m_pc;
`ifdef FETCH_IMM_EN
          m_owed = w[0];
`endif
          m_valid = !m_owed;
        end
        m_pc = m_pc + 1;
      end
      next_cycle();
    end
    hazardStall = 1'b0;
    branchTaken = 1'b0;
  endtask

  initial begin
    test_reset();
    test_boot();
    test_two_word();
    test_hazard();
    test_branch();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter BOOT_ADDR, default 32'd0, address of the 2-word reset vector (high word at BOOT_ADDR, low word at BOOT_ADDR+1).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port memInstruction  input  16  combinational read data from instruction memory.
REQ-005 SHALL have port readAddress  output  32  word address presented to instruction memory (combinational from state/pc).
REQ-006 SHALL have port memStall  output  1  drives memory stall input; high forces a zero word into the pipe.
REQ-007 SHALL have port hazardStall  input  1  hold request from the hazard unit.
REQ-008 SHALL have port branchTaken  input  1  redirect request, valid for one cycle.
REQ-009 SHALL have port branchTarget  input  32  redirect address.
REQ-010 SHALL have port instrOut  output  16  registered fetched instruction.
REQ-011 SHALL have port immOut  output  16  registered immediate word of a 2-word instruction.
REQ-012 SHALL have port instrValid  output  1  instrOut/immOut/pcOut valid this cycle.
REQ-013 SHALL have port pcOut  output  32  address of the instruction in instrOut.

Function
REQ-014 SHALL implement states BOOT_HI, BOOT_LO, RUN, IMM.
REQ-015 BOOT_HI: readAddress=BOOT_ADDR; latch memInstruction into pc[31:16]; next BOOT_LO.
REQ-016 BOOT_LO: readAddress=BOOT_ADDR+1; latch memInstruction into pc[15:0]; next RUN; instrValid stays 0 in both boot states.
REQ-017 RUN: readAddress=pc; when not held, instrOut<=memInstruction, pcOut<=pc, pc<=pc+1 (32-bit wrap, 0xFFFFFFFF+1=0).
REQ-018 RUN: if memInstruction[0]=1 (2-word instruction) SHALL go to IMM with instrValid<=0; else instrValid<=1 next cycle.
REQ-019 IMM: readAddress=pc; when not held, immOut<=memInstruction, pc<=pc+1, instrValid<=1, next RUN.
REQ-020 Fetch-to-instrValid latency SHALL be 1 cycle (1-word) or 2 cycles (2-word).
REQ-021 hazardStall=1 in RUN/IMM SHALL hold pc, state, instrOut, immOut, pcOut, instrValid unchanged and drive memStall=1.
REQ-022 branchTaken=1 in RUN/IMM SHALL win over hazardStall: pc<=branchTarget, state<=RUN, instrValid<=0, memStall=1 that cycle (flush).
REQ-023 branchTaken and hazardStall SHALL be ignored in BOOT_HI/BOOT_LO.
REQ-024 memStall SHALL be 0 in boot states and in RUN/IMM when neither hold nor redirect is active.
REQ-025 A redirect while in IMM SHALL discard the partially fetched instruction (no instrValid for it).

Reset
REQ-026 reset=1 SHALL asynchronously force state=BOOT_HI, pc=0, instrOut=0, immOut=0, pcOut=0, instrValid=0.
REQ-027 reset asserted mid-operation (any state) SHALL abort the fetch; after release, boot sequence restarts from BOOT_HI.

Configuration
REQ-028 Macro FETCH_IMM_EN defined: 2-word instruction support per REQ-018/019/025.
REQ-029 FETCH_IMM_EN undefined: IMM state absent, every word is a 1-word instruction, immOut tied to 0, memInstruction[0] ignored.

Verification
REQ-030 Memory M[0]=0x0000, M[1]=0x0010, release reset -> readAddress 0, 1, then 0x10; first instrValid 3 cycles after release with pcOut=0x10.
REQ-031 M[0x10]=0x1235 (bit0=1), M[0x11]=0xBEEF (FETCH_IMM_EN) -> one instrValid pulse, instrOut=0x1235, immOut=0xBEEF, pcOut=0x10, next fetch 0x12.
REQ-032 hazardStall held 3 cycles in RUN at pc=0x14 -> memStall=1, pc stays 0x14, outputs frozen 3 cycles, resumes at 0x14.
REQ-033 branchTaken=1 with hazardStall=1, branchTarget=0x200 -> next readAddress 0x200, instrValid=0 for one cycle, then valid with pcOut=0x200.
REQ-034 pc=0xFFFFFFFF, 1-word fetch -> next readAddress 0x00000000.
REQ-035 reset pulsed while in IMM -> instrValid=0 immediately, boot reads from address 0 again.
